// File: rtl/three_bit_adder.sv
// Registered 3-bit ripple-carry adder with carry-out, bit-sliced ports.

// Gate-level full-adder cell: sum and carry are purely combinational.
module three_bit_adder_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s_c,
  output logic co_c
);

  logic p;

  // Propagate term is shared by sum and carry.
  assign p    = a ^ b;
  assign s_c  = p ^ ci;
  assign co_c = (a & b) | (ci & p);

endmodule

module three_bit_adder (
  input  logic clk,
  input  logic rst_n,
  input  logic a0,
  input  logic a1,
  input  logic a2,
  input  logic b0,
  input  logic b1,
  input  logic b2,
  output logic sum0,
  output logic sum1,
  output logic sum2,
  output logic cout
);

  localparam int unsigned W = 3;

  logic [W-1:0] a_v;
  logic [W-1:0] b_v;
  logic [W-1:0] s_v;
  logic [W:0]   c_v;
  logic [W:0]   res_d;
  logic [W:0]   res_q;

  // Gather scalar operand bits into vectors, LSB at index 0.
  assign a_v    = {a2, a1, a0};
  assign b_v    = {b2, b1, b0};
  assign c_v[0] = 1'b0;

  // Ripple-carry chain of full-adder cells.
  for (genvar i = 0; i < W; i++) begin : g_fa
    three_bit_adder_fa u_fa (
      .a    (a_v[i]),
      .b    (b_v[i]),
      .ci   (c_v[i]),
      .s_c  (s_v[i]),
      .co_c (c_v[i+1])
    );
  end

  // Next result: carry-out of the last cell above the sum bits.
  always_comb begin
    res_d = '0;
    res_d = {c_v[W], s_v};
  end

  // Output register; reset clears immediately and discards any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end

  assign sum0 = res_q[0];
  assign sum1 = res_q[1];
  assign sum2 = res_q[2];
  assign cout = res_q[3];

endmodule

// File: tb/tb_three_bit_adder.sv
// Scoreboard bench for three_bit_adder: stimulus queues expectations, monitor compares.
`timescale 1ns/1ps
module tb_three_bit_adder;

  logic clk;
  logic rst_n;
  logic a0, a1, a2, b0, b1, b2;
  logic sum0, sum1, sum2, cout;

  int n_pass;
  int n_total;

  logic [3:0] exp_q[$];
  string      name_q[$];

  three_bit_adder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a0    (a0),
    .a1    (a1),
    .a2    (a2),
    .b0    (b0),
    .b1    (b1),
    .b2    (b2),
    .sum0  (sum0),
    .sum1  (sum1),
    .sum2  (sum2),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] dut_out();
    return {cout, sum2, sum1, sum0};
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got cout/sum=%b expected %b", name, act, exp);
  endtask

  task automatic drive(input logic [2:0] a, input logic [2:0] b);
    {a2, a1, a0} = a;
    {b2, b1, b0} = b;
  endtask

  // Issue one operand pair at the falling edge and queue its expected result.
  task automatic issue(input string name, input logic [2:0] a, input logic [2:0] b,
                       input logic [3:0] exp);
    @(negedge clk);
    drive(a, b);
    exp_q.push_back(exp);
    name_q.push_back(name);
  endtask

  // Monitor: an item queued before this edge shows up on the outputs just after it.
  initial begin
    forever begin
      @(posedge clk);
      if (exp_q.size() > 0) begin
        logic [3:0] e;
        string      n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        #1;
        check(n, dut_out(), e);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    drive(3'd7, 3'd7);

    // Reset held with A=7,B=7: outputs stay zero across edges.
    #2;
    check("reset_initial", dut_out(), 4'b0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_held", dut_out(), 4'b0000);
    end

    // Release reset; first edge gives 7+7 = 14 -> cout=1, sum=6.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_release_before_edge", dut_out(), 4'b0000);
    exp_q.push_back(4'b1110);
    name_q.push_back("after_reset_7p7");

    // Directed vectors, hand-computed.
    issue("no_ovf_6p1",   3'd6, 3'd1, 4'b0111);
    issue("mid_2p3",      3'd2, 3'd3, 4'b0101);
    issue("ovf_wrap_5p4", 3'd5, 3'd4, 4'b1001);
    issue("ovf_6p4",      3'd6, 3'd4, 4'b1010);
    issue("zero_0p0",     3'd0, 3'd0, 4'b0000);
    issue("edge_7p1",     3'd7, 3'd1, 4'b1000);

    // All 64 pairs on consecutive cycles.
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        issue($sformatf("exh_%0dp%0d", a, b), 3'(a), 3'(b), 4'(a + b));
      end
    end

    // Let the last result (7+7) reach the outputs, then reset between edges.
    @(posedge clk);
    #3;
    check("pre_async_reset", dut_out(), 4'b1110);
    drive(3'd5, 3'd5);
    rst_n = 1'b0;
    #1;
    check("async_reset_immediate", dut_out(), 4'b0000);
    @(posedge clk);
    #1;
    check("async_reset_held_edge", dut_out(), 4'b0000);

    // Release and confirm normal operation resumes with 5+5 = 10.
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(4'b1010);
    name_q.push_back("post_async_5p5");
    issue("post_async_3p3", 3'd3, 3'd3, 4'b0110);

    @(negedge clk);
    @(negedge clk);
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
